// File: rtl/ov7670_init_pkg.sv
// Shared types and constants for the OV7670 power-up/configuration sequencer.
package ov7670_init_pkg;

    typedef enum logic [3:0] {
        RESET_HOLD = 4'd0,
        SETTLE     = 4'd1,
        FETCH      = 4'd2,
        DECODE     = 4'd3,
        ISSUE      = 4'd4,
        WAIT       = 4'd5,
        DELAY      = 4'd6,
        DONE       = 4'd7,
        ERROR      = 4'd8
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] value;
    } rom_entry_t;

    localparam logic [15:0] END_MARKER   = 16'hFFFF;
    localparam logic [7:0]  DELAY_PREFIX = 8'hF0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous register table for OV7670 QVGA / RGB444; {reg, value} per entry,
// delay entries use reg 0xF0, table ends with 16'hFFFF.
module ov7670_reg_rom
    import ov7670_init_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [15:0]           data_o
);

    logic [15:0] w_data;
    logic [15:0] r_data;

    always_comb begin
        w_data = END_MARKER;
        case (int'(addr_i))
            0:  w_data = 16'h1280;  // COM7 soft reset; needs the delay that follows
            1:  w_data = 16'hF001;
            2:  w_data = 16'h1101;
            3:  w_data = 16'h1214;
            4:  w_data = 16'h0C04;
            5:  w_data = 16'h3E19;
            6:  w_data = 16'h703A;
            7:  w_data = 16'h7135;
            8:  w_data = 16'h7211;
            9:  w_data = 16'h73F1;
            10: w_data = 16'hA202;
            11: w_data = 16'h8C02;
            12: w_data = 16'h0400;
            13: w_data = 16'h40D0;
            14: w_data = 16'h3A04;
            15: w_data = 16'h1418;
            16: w_data = 16'h4FB3;
            17: w_data = 16'h50B3;
            18: w_data = 16'h5100;
            19: w_data = 16'h523D;
            20: w_data = 16'h53A7;
            21: w_data = 16'h54E4;
            22: w_data = 16'h589E;
            23: w_data = 16'h3DC0;
            24: w_data = 16'h13E7;
            default: w_data = END_MARKER;
        endcase
    end

    always_ff @(posedge clk_i) begin
        r_data <= w_data;
    end

    assign data_o = r_data;

endmodule

// File: rtl/ov7670_init_sequencer.sv
// OV7670 reset/settle sequencing and ROM-driven SCCB register writes with NACK retry.
// Optional watchdog on the write-done wait: define OV7670_INIT_WATCHDOG_EN.
module ov7670_init_sequencer
    import ov7670_init_pkg::*;
#(
    parameter int ROM_ADDR_WIDTH    = 8,
    parameter int RESET_HOLD_CYCLES = 100000,
    parameter int SETTLE_CYCLES     = 1000000,
    parameter int DELAY_UNIT_CYCLES = 100000,
    parameter int MAX_RETRIES       = 3,
    parameter int TIMEOUT_CYCLES    = 50000
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [15:0]               rom_data_i,
    output logic                      cmos_reset_o,
    output logic                      wr_req_o,
    input  logic                      wr_ready_i,
    output logic [7:0]                wr_reg_o,
    output logic [7:0]                wr_data_o,
    input  logic                      wr_done_i,
    input  logic                      wr_nack_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [ROM_ADDR_WIDTH-1:0] fail_addr_o
);

    // One shared down/up counter covers hold, settle, delay and watchdog windows.
    localparam int CNT_MAX = max_int(max_int(RESET_HOLD_CYCLES, SETTLE_CYCLES),
                                     max_int(255 * DELAY_UNIT_CYCLES, TIMEOUT_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0]          HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]          SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]          UNIT        = CNT_W'(DELAY_UNIT_CYCLES);
    localparam logic [RTY_W-1:0]          RTY_LIM     = RTY_W'(MAX_RETRIES);
    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_ADDR   = '1;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [RTY_W-1:0]          r_retries;
    logic [ROM_ADDR_WIDTH-1:0] r_addr;
    logic [ROM_ADDR_WIDTH-1:0] r_fail_addr;
    logic                      r_cmos_rst;
    logic                      r_wr_req;
    logic [7:0]                r_wr_reg;
    logic [7:0]                r_wr_data;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;

    rom_entry_t w_entry;
    logic       w_timeout;
    logic       w_wr_fin;
    logic       w_wr_fail;
    logic       w_advance;

    assign w_entry = rom_entry_t'(rom_data_i);

`ifdef OV7670_INIT_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_timeout = (r_cnt == TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // A timeout without a done pulse is handled exactly like a NACK.
    assign w_wr_fin  = wr_done_i | w_timeout;
    assign w_wr_fail = wr_done_i ? wr_nack_i : w_timeout;

    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            DECODE:  w_advance = (rom_data_i != END_MARKER) && (w_entry.reg_addr == DELAY_PREFIX)
                                 && (w_entry.value == 8'h00);
            DELAY:   w_advance = (r_cnt <= CNT_W'(1));
            WAIT:    w_advance = w_wr_fin && !w_wr_fail;
            default: w_advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state     <= RESET_HOLD;
            r_cnt       <= '0;
            r_retries   <= '0;
            r_addr      <= '0;
            r_fail_addr <= '0;
            r_cmos_rst  <= 1'b0;
            r_wr_req    <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                RESET_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state    <= SETTLE;
                        r_cmos_rst <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FETCH: r_state <= DECODE;
                DECODE: begin
                    if (rom_data_i == END_MARKER) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_entry.reg_addr == DELAY_PREFIX) begin
                        if (w_entry.value != 8'h00) begin
                            r_state <= DELAY;
                            r_cnt   <= CNT_W'(w_entry.value) * UNIT;
                        end
                    end else begin
                        r_wr_reg  <= w_entry.reg_addr;
                        r_wr_data <= w_entry.value;
                        r_retries <= '0;
                        r_wr_req  <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_wr_req && wr_ready_i) begin
                        r_wr_req <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_wr_fin) begin
                        if (w_wr_fail) begin
                            if (r_retries < RTY_LIM) begin
                                r_retries <= r_retries + RTY_W'(1);
                                r_wr_req  <= 1'b1;
                                r_state   <= ISSUE;
                            end else begin
                                r_state     <= ERROR;
                                r_busy      <= 1'b0;
                                r_error     <= 1'b1;
                                r_fail_addr <= r_addr;
                            end
                        end
                    end
`ifdef OV7670_INIT_WATCHDOG_EN
                    else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                DELAY: begin
                    if (r_cnt > CNT_W'(1))
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                DONE, ERROR: begin
                    if (start_i) begin
                        r_state    <= RESET_HOLD;
                        r_cmos_rst <= 1'b0;
                        r_cnt      <= '0;
                        r_addr     <= '0;
                        r_retries  <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                default: r_state <= RESET_HOLD;
            endcase

            // Index never wraps: the last slot finishes the sequence.
            if (w_advance) begin
                if (r_addr == LAST_ADDR) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_addr  <= r_addr + ROM_ADDR_WIDTH'(1);
                    r_state <= FETCH;
                end
            end
        end
    end

    // Request drops in the reset cycle itself so the shared SCCB master never latches it.
    assign wr_req_o     = r_wr_req & reset_i;
    assign rom_addr_o   = r_addr;
    assign cmos_reset_o = r_cmos_rst;
    assign wr_reg_o     = r_wr_reg;
    assign wr_data_o    = r_wr_data;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign fail_addr_o  = r_fail_addr;

endmodule

// File: doc/ov7670_init_sequencer.md
Name: ov7670_init_sequencer

Overview:
- Power-up and configuration sequencer for the OV7670 camera.
- Drives the camera reset pin through its hold and settle windows, then walks a register ROM and issues one SCCB write per entry to the existing I2C/SCCB byte-write master.
- Handles inline delay entries, retries NACKed writes, and reports done or error to the top level.
- Sits between the top level and the SCCB master; the top only sees start, status and the camera reset pin.

Parameters:
- ROM_ADDR_WIDTH, 8, width of the ROM index (max 256 entries).
- RESET_HOLD_CYCLES, 100000, cycles cmos_reset_o is held low.
- SETTLE_CYCLES, 1000000, cycles to wait after reset release before the first write.
- DELAY_UNIT_CYCLES, 100000, cycles per unit of a delay entry.
- MAX_RETRIES, 3, extra attempts allowed per NACKed entry.
- TIMEOUT_CYCLES, 50000, done-wait limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous reset, active-low.
- start_i  in  1  re-init pulse; honoured only in DONE or ERROR.
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM index.
- rom_data_i  in  16  {reg[15:8], value[7:0]}; synchronous ROM, 1-cycle latency.
- cmos_reset_o  out  1  camera reset, active-low.
- wr_req_o  out  1  write request to SCCB master.
- wr_ready_i  in  1  SCCB master can accept a request.
- wr_reg_o  out  8  register address.
- wr_data_o  out  8  register value.
- wr_done_i  in  1  1-cycle pulse, transaction finished.
- wr_nack_i  in  1  valid with wr_done_i; 1 means NACK.
- busy_o  out  1  sequence in progress.
- done_o  out  1  all entries written.
- error_o  out  1  retries exhausted.
- fail_addr_o  out  ROM_ADDR_WIDTH  ROM index of the failing entry.

Behaviour:
- Reset values: state=RESET_HOLD, cmos_reset_o=0, wr_req_o=0, wr_reg_o=0, wr_data_o=0, rom_addr_o=0, busy_o=1, done_o=0, error_o=0, fail_addr_o=0, all counters 0.
- RESET_HOLD:
  - cmos_reset_o=0 for exactly RESET_HOLD_CYCLES cycles, then go to SETTLE.
  - Also entered from DONE/ERROR on start_i; this clears done_o, error_o, the ROM index and the retry count.
- SETTLE: cmos_reset_o=1; wait SETTLE_CYCLES cycles, then go to FETCH.
- FETCH: present rom_addr_o; wait 1 cycle, then go to DECODE.
- DECODE:
  - 16'hFFFF is the end marker: go to DONE.
  - Upper byte 8'hF0 is a delay entry: go to DELAY with count = value×DELAY_UNIT_CYCLES. A value of 0 means zero delay; advance immediately.
  - Any other entry: latch wr_reg_o/wr_data_o, clear the retry count, go to ISSUE.
- ISSUE:
  - Assert wr_req_o.
  - Handshake completes on the cycle wr_req_o and wr_ready_i are both high.
  - wr_req_o deasserts the next cycle; go to WAIT.
  - wr_reg_o/wr_data_o are stable from ISSUE through WAIT.
- WAIT, on wr_done_i:
  - nack=0: advance.
  - nack=1 and retries<MAX_RETRIES: increment retries, return to ISSUE.
  - Otherwise: go to ERROR.
- DELAY: count down, then advance.
- Advance rule:
  - If the index equals 2^ROM_ADDR_WIDTH-1, go to DONE (no wrap).
  - Otherwise increment the index and go to FETCH.
- DONE: busy_o=0, done_o=1, cmos_reset_o=1; held until start_i.
- ERROR:
  - busy_o=0, error_o=1, fail_addr_o=failing index; cmos_reset_o stays 1.
  - Held until start_i.
- start_i while busy is ignored.
- wr_done_i outside WAIT is ignored.
- A write to reg 0x12 with bit7 set gets no special handling; the ROM follows it with a delay entry.
- Reset mid-transaction drops wr_req_o the same cycle. The SCCB master shares reset_i, so no orphan done pulse is expected.
- Counter widths are sized with $clog2 from the parameters. A delay product that exceeds the counter width is a configuration error.

Optional Feature:
- Macro: OV7670_INIT_WATCHDOG_EN.
- Defined: a counter runs in WAIT and clears on entry to WAIT.
  - Reaching TIMEOUT_CYCLES without wr_done_i is treated as a NACK and goes through the same retry/ERROR path.
  - The SCCB master is not reset by this block.
- Undefined: no counter; WAIT holds indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package ov7670_init_pkg holds:
  - state_t enum (RESET_HOLD, SETTLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE, ERROR).
  - rom_entry_t packed struct {reg, value}.
  - Constants END_MARKER=16'hFFFF and DELAY_PREFIX=8'hF0.
- Sub-module ov7670_reg_rom: synchronous 16-bit ROM holding the OV7670 QVGA/RGB444 table. It is instantiated beside the sequencer, not inside it.

Test Plan (RESET_HOLD=10, SETTLE=20, DELAY_UNIT=4, MAX_RETRIES=3, ROM_ADDR_WIDTH=4):
- Release reset -> cmos_reset_o low for exactly 10 cycles, then high; first wr_req_o no earlier than 20 cycles after release.
- ROM {1280, F005, 1101, FFFF}, ready always, done 5 cycles after accept, nack=0 -> writes (12,80) then (11,01); gap between first done and next req ≥ 20 cycles; done_o=1, busy_o=0.
- wr_ready_i low for 7 cycles during ISSUE -> wr_req_o, wr_reg_o and wr_data_o held constant; exactly one accept.
- ROM entry 2 NACKs 4 times -> 4 accepts for index 2, then error_o=1, fail_addr_o=2, no further req; start_i -> cmos_reset_o low 10 cycles and the sequence restarts from index 0.
- All 16 entries are writes with no end marker -> 16 writes, then done_o=1, rom_addr_o does not wrap to 0; start_i pulsed mid-sequence is ignored.
- With OV7670_INIT_WATCHDOG_EN defined (TIMEOUT=30) and wr_done_i withheld -> 4 timeouts, then error_o=1; without the macro -> state remains WAIT after 1000 cycles.
